// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: receive-side frame sequencer behind the sync-word demodulator.
// Deserialises the post-sync bit stream LSB-first, parses LEN / payload /
// additive checksum, and requests frame end (fsc_end) from the demodulator.
//
// Handshake: there is no backpressure. bit_in is meaningful only while
// bit_valid=1 (one bit per clk); byte_valid is a one-cycle strobe that
// qualifies byte_out, and the consumer must take every byte it is offered.
module rx_frame_ctrl #(
  parameter int MAX_LEN = 64,
  parameter bit CHK_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       abort,
  output logic       fsc_end,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic [7:0] frame_len,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CSUM    = 3'd3,
    S_END     = 3'd4
  } state_t;

  state_t     state;
  state_t     state_d;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [7:0] sum;

  logic       active;
  logic       byte_full;
  logic [7:0] asm_byte;
  logic       len_ok;
  logic       pay_emit;
  logic       done_d;
  logic       shift_en;
  logic [1:0] err_d;

  // Next-state decode; abort outranks a dropped sync, which outranks a completing byte.
  always_comb begin
    active    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    asm_byte  = {bit_in, shreg[7:1]};
    byte_full = (bit_cnt == 3'd7);
    shift_en  = bit_valid && ((state == S_IDLE) || (active && !abort));
    state_d   = state;
    err_d     = err_code;
    done_d    = 1'b0;
    len_ok    = 1'b0;
    pay_emit  = 1'b0;
    if (active && abort) begin
      err_d   = 2'd3;
      done_d  = 1'b1;
      state_d = S_END;
    end else if (active && !bit_valid) begin
      // Sync lost mid-frame: report and re-arm without requesting frame end.
      err_d   = 2'd3;
      done_d  = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bit_valid) state_d = S_LEN;
        end
        S_LEN: begin
          if (byte_full) begin
            if (asm_byte > MAX_LEN_B) begin
              err_d   = 2'd1;
              done_d  = 1'b1;
              state_d = S_END;
            end else begin
              len_ok  = 1'b1;
              err_d   = 2'd0;
              state_d = (asm_byte == 8'd0) ? S_CSUM : S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (byte_full) begin
            pay_emit = 1'b1;
            if (byte_cnt + 8'd1 == frame_len) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (byte_full) begin
            if (CHK_EN && (asm_byte != sum)) err_d = 2'd2;
            done_d  = 1'b1;
            state_d = S_END;
          end
        end
        S_END: begin
          if (!bit_valid) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  // Deserialiser, frame counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg       <= 8'd0;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 8'd0;
      sum         <= 8'd0;
      fsc_end     <= 1'b0;
      byte_out    <= 8'd0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_len   <= 8'd0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      frame_start <= len_ok;
      byte_valid  <= pay_emit;
      frame_done  <= done_d;
      frame_err   <= done_d && (err_d != 2'd0);
      err_code    <= err_d;
      fsc_end     <= (state_d == S_END);
      // Leaving the frame discards any partial byte so the next frame starts aligned.
      if ((state_d == S_IDLE) || (state_d == S_END)) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        shreg   <= asm_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (pay_emit) byte_out <= asm_byte;
      if (len_ok) begin
        frame_len <= asm_byte;
        sum       <= 8'd0;
        byte_cnt  <= 8'd0;
      end else if (pay_emit) begin
        sum      <= sum + asm_byte;
        byte_cnt <= byte_cnt + 8'd1;
      end
    end
  end

endmodule
